// File: rtl/hdc_bundle_classifier_if.sv
// Stream, class-memory write and result handshake bundle for hdc_bundle_classifier.
// master drives beats, memory writes and out_ready; slave is the classifier.
interface hdc_bundle_classifier_if #(
    parameter int LANES   = 16,
    parameter int CNT_W   = 8,
    parameter int CID_W   = 4,
    parameter int CHUNK_W = 6,
    parameter int DIST_W  = 11
);
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*CNT_W-1:0]   in_cnt;
    logic                     cm_we;
    logic [CID_W-1:0]         cm_class;
    logic [CHUNK_W-1:0]       cm_chunk;
    logic [LANES-1:0]         cm_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [CID_W-1:0]         out_class;
    logic [DIST_W-1:0]        out_dist;

    modport master (
        output in_valid, in_cnt, cm_we, cm_class, cm_chunk, cm_data, out_ready,
        input  in_ready, out_valid, out_class, out_dist
    );

    modport slave (
        input  in_valid, in_cnt, cm_we, cm_class, cm_chunk, cm_data, out_ready,
        output in_ready, out_valid, out_class, out_dist
    );
endinterface

// File: rtl/hdc_bundle_classifier.sv
// Binarizes streamed bundle counts into a query hypervector, accumulates Hamming
// distance to every stored class, then scans classes for the nearest one.
module hdc_bundle_classifier #(
    parameter int DIM         = 1024,
    parameter int CNT_W       = 8,
    parameter int LANES       = 16,
    parameter int NUM_CLASSES = 10,
    parameter int THRESH      = 72
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hdc_bundle_classifier_if.slave  bus
);
    localparam int BEATS  = DIM / LANES;
    localparam int CID_W  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DIST_W = $clog2(DIM + 1);
    localparam int POP_W  = $clog2(LANES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SEARCH, S_DONE} state_t;

    state_t                              state_q, state_d;
    logic [BEAT_W-1:0]                   beat_q;
    logic [CID_W-1:0]                    idx_q;
    logic [NUM_CLASSES-1:0][DIST_W-1:0]  acc_q;
    logic [DIST_W-1:0]                   best_dist_q;
    logic [CID_W-1:0]                    best_class_q;
    logic [CID_W-1:0]                    out_class_q;
    logic [DIST_W-1:0]                   out_dist_q;

    logic [LANES-1:0]                    mem_q [NUM_CLASSES][BEATS];
    logic [LANES-1:0]                    query;
    logic [NUM_CLASSES-1:0][POP_W-1:0]   pop_all;

    logic in_ready_int;
    logic accept;
    logic last_beat;
    logic last_idx;
    logic take;
    logic [DIST_W-1:0] cand;

    assign in_ready_int = (state_q == S_IDLE) || (state_q == S_ACCUM);
    assign accept       = bus.in_valid && in_ready_int;
    assign last_beat    = (beat_q == BEAT_W'(BEATS - 1));
    assign last_idx     = (idx_q == CID_W'(NUM_CLASSES - 1));
    assign cand         = acc_q[idx_q];
    // Strict less keeps the lowest index on ties.
    assign take         = (idx_q == '0) || (cand < best_dist_q);

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_class = out_class_q;
    assign bus.out_dist  = out_dist_q;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : gen_query
            assign query[gi] = bus.in_cnt[gi*CNT_W +: CNT_W] > CNT_W'(THRESH);
        end
    endgenerate

    // beat_q is 0 whenever the block sits in IDLE, so the first beat reads chunk 0.
    generate
        for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : gen_pop
            logic [LANES-1:0] diff;
            logic [POP_W-1:0] pop;
            assign diff = query ^ mem_q[gi][beat_q];
            always_comb begin
                pop = '0;
                for (int k = 0; k < LANES; k++) begin
                    pop = pop + POP_W'(diff[k]);
                end
            end
            assign pop_all[gi] = pop;
        end
    endgenerate

    // Reads are combinational from the registered array, so a same-cycle write is not seen.
    always_ff @(posedge clk) begin
        if (bus.cm_we && (state_q == S_IDLE) && (bus.cm_class < CID_W'(NUM_CLASSES))) begin
            mem_q[bus.cm_class][bus.cm_chunk] <= bus.cm_data;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = last_beat ? S_SEARCH : S_ACCUM;
            S_ACCUM:  if (accept && last_beat) state_d = S_SEARCH;
            S_SEARCH: if (last_idx) state_d = S_DONE;
            S_DONE:   if (bus.out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q       <= '0;
            idx_q        <= '0;
            acc_q        <= '0;
            best_dist_q  <= '0;
            best_class_q <= '0;
            out_class_q  <= '0;
            out_dist_q   <= '0;
        end else begin
            if (accept) begin
                beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
                for (int c = 0; c < NUM_CLASSES; c++) begin
                    if (state_q == S_IDLE) begin
                        acc_q[c] <= DIST_W'(pop_all[c]);
                    end else begin
                        acc_q[c] <= acc_q[c] + DIST_W'(pop_all[c]);
                    end
                end
            end
            if (state_q == S_SEARCH) begin
                if (take) begin
                    best_dist_q  <= cand;
                    best_class_q <= idx_q;
                end
                if (last_idx) begin
                    idx_q       <= '0;
                    out_class_q <= take ? idx_q : best_class_q;
                    out_dist_q  <= take ? cand : best_dist_q;
                end else begin
                    idx_q <= idx_q + CID_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_hdc_bundle_classifier.sv
// Randomized bench for hdc_bundle_classifier against a per-dimension
// nearest-class reference model.
module tb_hdc_bundle_classifier;
    localparam int DIM = 1024;
    localparam int LANES = 16;
    localparam int NCLS = 10;
    localparam int BEATS = DIM / LANES;
    localparam int THR = 72;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hdc_bundle_classifier_if bus ();

    hdc_bundle_classifier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DIM-1:0] cls [NCLS];
    logic [7:0]     cnt [DIM];
    int checks = 0;
    int errors = 0;
    int vec_no = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Nearest class by full Hamming distance over the binarized counts.
    task automatic model(output int ec, output int ed);
        ec = 0;
        ed = DIM + 1;
        for (int c = 0; c < NCLS; c++) begin
            int d = 0;
            for (int i = 0; i < DIM; i++) begin
                if ((cnt[i] > THR) != cls[c][i]) d++;
            end
            if (d < ed) begin
                ed = d;
                ec = c;
            end
        end
    endtask

    function automatic logic [DIM-1:0] query_bits();
        logic [DIM-1:0] q;
        for (int i = 0; i < DIM; i++) q[i] = (cnt[i] > THR);
        return q;
    endfunction

    task automatic rand_counts(input int lo, input int hi);
        for (int i = 0; i < DIM; i++) cnt[i] = 8'($urandom_range(lo, hi));
    endtask

    task automatic rand_class(input int c);
        for (int w = 0; w < DIM / 32; w++) cls[c][w*32 +: 32] = $urandom;
    endtask

    task automatic load_class(input int c);
        for (int ch = 0; ch < BEATS; ch++) begin
            bus.cm_we    = 1'b1;
            bus.cm_class = 4'(c);
            bus.cm_chunk = 6'(ch);
            bus.cm_data  = cls[c][ch*LANES +: LANES];
            tick();
        end
        bus.cm_we = 1'b0;
    endtask

    task automatic load_all();
        for (int c = 0; c < NCLS; c++) load_class(c);
    endtask

    task automatic send_beats(input int nbeats, input int stall_pct);
        for (int b = 0; b < nbeats; b++) begin
            while ($urandom_range(0, 99) < stall_pct) begin
                bus.in_valid = 1'b0;
                bus.in_cnt   = {4{$urandom}};
                tick();
            end
            bus.in_valid = 1'b1;
            for (int k = 0; k < LANES; k++) bus.in_cnt[k*8 +: 8] = cnt[b*LANES + k];
            if (b == 0) check_val("in_ready_first_beat", 32'(bus.in_ready), 1);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    // Waits for out_valid, checks latency and result against the model.
    task automatic wait_and_check(input string tag);
        int n = 0;
        int ec, ed;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        check_val({tag, "_latency"}, 32'(n), 10);
        model(ec, ed);
        check_val({tag, "_class"}, 32'(bus.out_class), 32'(ec));
        check_val({tag, "_dist"}, 32'(bus.out_dist), 32'(ed));
        $display("vector %0d %s: class %0d dist %0d (model %0d/%0d) latency %0d",
                 vec_no, tag, bus.out_class, bus.out_dist, ec, ed, n);
        vec_no++;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_val("idle_after_pop_in_ready", 32'(bus.in_ready), 1);
        check_val("idle_after_pop_out_valid", 32'(bus.out_valid), 0);
    endtask

    initial begin
        logic [DIM-1:0] q;
        logic [3:0]  held_class;
        logic [10:0] held_dist;

        bus.in_valid  = 1'b0;
        bus.in_cnt    = '0;
        bus.cm_we     = 1'b0;
        bus.cm_class  = '0;
        bus.cm_chunk  = '0;
        bus.cm_data   = '0;
        bus.out_ready = 1'b0;

        // Reset with random traffic on the inputs
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid  = 1'($urandom);
            bus.in_cnt    = {4{$urandom}};
            bus.out_ready = 1'($urandom);
            tick();
        end
        check_val("rst_out_valid", 32'(bus.out_valid), 0);
        check_val("rst_out_class", 32'(bus.out_class), 0);
        check_val("rst_out_dist", 32'(bus.out_dist), 0);
        check_val("rst_in_ready", 32'(bus.in_ready), 1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        tick();

        // Class 3 equals the query
        rand_counts(50, 95);
        for (int c = 0; c < NCLS; c++) rand_class(c);
        cls[3] = query_bits();
        load_all();
        send_beats(BEATS, 0);
        wait_and_check("exact");
        check_val("exact_class3", 32'(bus.out_class), 3);
        check_val("exact_dist0", 32'(bus.out_dist), 0);
        consume();

        // Threshold edge: 72 binarizes to 0, 73 to 1
        for (int c = 0; c < NCLS; c++) cls[c] = '1;
        for (int i = 0; i < DIM; i++) cnt[i] = 8'd72;
        load_all();
        send_beats(BEATS, 0);
        wait_and_check("thr72");
        check_val("thr72_dist", 32'(bus.out_dist), 1024);
        consume();
        for (int i = 0; i < DIM; i++) cnt[i] = 8'd73;
        send_beats(BEATS, 0);
        wait_and_check("thr73");
        check_val("thr73_dist", 32'(bus.out_dist), 0);
        consume();

        // Tie between classes 2 and 5 at distance 17
        rand_counts(40, 110);
        q = query_bits();
        for (int c = 0; c < NCLS; c++) rand_class(c);
        cls[2] = q;
        cls[5] = q;
        for (int i = 0; i < 17; i++) begin
            cls[2][i]       = ~q[i];
            cls[5][300 + i] = ~q[300 + i];
        end
        load_all();
        send_beats(BEATS, 0);
        wait_and_check("tie");
        check_val("tie_class", 32'(bus.out_class), 2);
        check_val("tie_dist", 32'(bus.out_dist), 17);
        consume();

        // Backpressure: result held, in_ready low, writes to the winner ignored
        rand_counts(50, 95);
        for (int c = 0; c < NCLS; c++) rand_class(c);
        load_all();
        send_beats(BEATS, 0);
        wait_and_check("bp");
        held_class = bus.out_class;
        held_dist  = bus.out_dist;
        for (int i = 0; i < 20; i++) begin
            bus.cm_we    = 1'b1;
            bus.cm_class = held_class;
            bus.cm_chunk = 6'(i);
            bus.cm_data  = ~cls[held_class][i*LANES +: LANES];
            tick();
            check_val("bp_out_valid", 32'(bus.out_valid), 1);
            check_val("bp_out_class", 32'(bus.out_class), 32'(held_class));
            check_val("bp_out_dist", 32'(bus.out_dist), 32'(held_dist));
            check_val("bp_in_ready", 32'(bus.in_ready), 0);
        end
        bus.cm_we = 1'b0;
        consume();
        send_beats(BEATS, 30);
        wait_and_check("bp_stalled_rerun");
        check_val("bp_rerun_dist", 32'(bus.out_dist), 32'(held_dist));
        consume();

        // Abort mid-vector with reset, memory must survive
        rand_counts(50, 95);
        send_beats(31, 0);
        rst_n = 1'b0;
        #1;
        check_val("abort_in_ready", 32'(bus.in_ready), 1);
        check_val("abort_out_valid", 32'(bus.out_valid), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        rand_counts(50, 95);
        send_beats(BEATS, 0);
        wait_and_check("abort_new");
        consume();

        // Randomized vectors with input stalls
        for (int r = 0; r < 3; r++) begin
            rand_counts(0, 255);
            for (int c = 0; c < NCLS; c++) rand_class(c);
            load_all();
            send_beats(BEATS, 25);
            wait_and_check("rand");
            consume();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
